// File: rtl/romulus_pdi_loader_pkg.sv
// Shared definitions for the Romulus pdi loader: datapath bus width, FSM state
// encoding and the last-word byte-count saturation helper.
package romulus_pdi_loader_pkg;

    localparam int BUSW = 128;

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    // in_bytes is 3 bits wide, but a 32-bit word carries at most 4 bytes
    function automatic logic [2:0] sat_bytes(input logic [2:0] bytes);
        return (bytes > 3'd4) ? 3'd4 : bytes;
    endfunction

endpackage

// File: rtl/romulus_pdi_loader_pad_mask.sv
// Maps a block length (0..16 bytes) to a valid-byte mask; bit 15 is byte 0,
// i.e. the byte carried in the top bits of the block.
module romulus_pdi_loader_pad_mask (
    input  logic [4:0]  len,
    output logic [15:0] mask
);

    // byte i is valid when its index lies below the block length
    always_comb begin
        mask = 16'h0000;
        for (int i = 0; i < 16; i++) begin
            mask[15-i] = (5'(i) < len);
        end
    end

endmodule

// File: rtl/romulus_pdi_loader.sv
// Assembles 32-bit pdi words MSB-first into 128-bit padded blocks with a per-byte
// decrypt mask. Define ROMULUS_PDI_LOADER_SKID_EN to accept a word while a block drains.
module romulus_pdi_loader
    import romulus_pdi_loader_pkg::*;
#(
    parameter int IN_W  = 32,
    parameter int BLK_W = BUSW,
    parameter int WORDS = BLK_W / IN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IN_W-1:0]   in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    input  logic [2:0]        in_bytes,
    input  logic              in_decrypt,
    output logic [BLK_W-1:0]  out_pdi,
    output logic [15:0]       out_decrypt,
    output logic [4:0]        out_len,
    output logic              out_padded,
    output logic              out_last,
    output logic              out_valid,
    input  logic              out_ready
);

    state_t            state_r;
    logic [1:0]        cnt_r;
    logic [BLK_W-1:0]  acc_r;
    logic [WORDS-1:0]  wdec_r;
    logic              ready_r;

    logic              take_s;
    logic              close_s;
    logic [1:0]        slot_s;
    logic [2:0]        nbytes_s;
    logic [4:0]        len_s;
    logic [BLK_W-1:0]  base_s;
    logic [BLK_W-1:0]  blk_s;
    logic [WORDS-1:0]  bdec_s;
    logic [BLK_W-1:0]  pdi_s;
    logic [15:0]       dec_s;
    logic [15:0]       mask_s;

`ifdef ROMULUS_PDI_LOADER_SKID_EN
    assign in_ready = ready_r | ((state_r == HOLD) & out_ready);
`else
    assign in_ready = ready_r;
`endif

    assign take_s   = in_valid & in_ready;
    // a word taken while draining a block always starts the next block at slot 0
    assign slot_s   = (state_r == FILL) ? cnt_r : 2'd0;
    assign close_s  = in_last | (slot_s == 2'd3);
    assign nbytes_s = in_last ? sat_bytes(in_bytes) : 3'd4;
    assign len_s    = {1'b0, slot_s, 2'b00} + {2'b00, nbytes_s};
    assign base_s   = (state_r == FILL) ? acc_r : 128'd0;

    romulus_pdi_loader_pad_mask u_pad_mask (
        .len  (len_s),
        .mask (mask_s)
    );

    // merge the incoming word and its decrypt flag into the partial block
    always_comb begin
        blk_s  = 128'd0;
        bdec_s = 4'd0;
        for (int w = 0; w < WORDS; w++) begin
            blk_s[BLK_W-1-IN_W*w -: IN_W] = (2'(w) == slot_s) ? in_data
                                          : base_s[BLK_W-1-IN_W*w -: IN_W];
            bdec_s[w] = (2'(w) == slot_s) ? in_decrypt
                      : ((state_r == FILL) ? wdec_r[w] : 1'b0);
        end
    end

    // zero bytes past the length, stamp the length byte, mask decrypt flags
    always_comb begin
        pdi_s = 128'd0;
        dec_s = 16'h0000;
        for (int i = 0; i < 15; i++) begin
            pdi_s[BLK_W-1-8*i -: 8] = mask_s[15-i] ? blk_s[BLK_W-1-8*i -: 8] : 8'd0;
        end
        pdi_s[7:0] = (len_s == 5'd16) ? blk_s[7:0] : {3'd0, len_s};
        for (int i = 0; i < 16; i++) begin
            dec_s[15-i] = mask_s[15-i] & bdec_s[i/4];
        end
    end

    // block FSM: accumulate in FILL, present the block in HOLD until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= FILL;
            cnt_r       <= 2'd0;
            acc_r       <= 128'd0;
            wdec_r      <= 4'd0;
            ready_r     <= 1'b0;
            out_pdi     <= 128'd0;
            out_decrypt <= 16'h0000;
            out_len     <= 5'd0;
            out_padded  <= 1'b0;
            out_last    <= 1'b0;
            out_valid   <= 1'b0;
        end else begin
            case (state_r)
                FILL: ready_r <= 1'b1;
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state_r   <= FILL;
                        ready_r   <= 1'b1;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: state_r <= FILL;
            endcase
            // takes only happen in FILL, or in HOLD while the block drains
            if (take_s) begin
                acc_r  <= blk_s;
                wdec_r <= bdec_s;
                if (close_s) begin
                    out_pdi     <= pdi_s;
                    out_decrypt <= dec_s;
                    out_len     <= len_s;
                    out_padded  <= (len_s != 5'd16);
                    out_last    <= in_last;
                    out_valid   <= 1'b1;
                    state_r     <= HOLD;
                    ready_r     <= 1'b0;
                    cnt_r       <= 2'd0;
                end else begin
                    cnt_r <= slot_s + 2'd1;
                end
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: doc/romulus_pdi_loader.md
Name: romulus_pdi_loader

Overview:
- Front end of the Romulus datapath's pdi/decrypt interface; it is the writer side that feeds the datapath's BUSW-wide block input.
- Accepts 32-bit public-data words (AD, plaintext or ciphertext) over valid/ready and assembles them MSB-first into 128-bit blocks.
- Applies Romulus padding to partial blocks: zero fill, then the last byte holds the valid-byte count.
- Emits each block with a per-byte decrypt mask, so padded bytes are never taken from pdo.

Parameters:
- IN_W, 32, input word width in bits; fixed at 32, other values unsupported.
- BLK_W, 128, output block width; equals BUSW from romulus_config_pkg.v.
- WORDS, BLK_W/IN_W (4), number of words per block.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  input word; byte 0 is in_data[31:24].
- in_valid  in  1  in_data is valid.
- in_ready  out  1  loader accepts a word this cycle.
- in_last  in  1  word is the last of its segment.
- in_bytes  in  3  valid bytes in this word (0..4); only meaningful when in_last=1.
- in_decrypt  in  1  segment is ciphertext; sampled on every accepted word.
- out_pdi  out  128  block to the datapath's pdi; first word in [127:96].
- out_decrypt  out  16  per-byte decrypt mask; bit 15 corresponds to out_pdi[127:120].
- out_len  out  5  valid data bytes in the block (0..16).
- out_padded  out  1  block was padded (out_len<16).
- out_last  out  1  block closes the segment.
- out_valid  out  1  block is available.
- out_ready  in  1  datapath consumes the block.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: FSM in FILL; word count 0; out_pdi, out_decrypt, out_len, out_padded, out_last and out_valid all 0; in_ready becomes 1 one cycle after rst deasserts.
- A reset mid-block or during HOLD discards all accumulated data, with no output.
- FSM states:
  - FILL: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Transfer happens when in_valid&in_ready.
- In FILL, an accepted word goes to slot cnt: out_pdi[127-32*cnt -: 32].
  - Word not last: all 4 bytes are valid; cnt increments.
  - At cnt=3, or when in_last=1: go to HOLD next cycle and reset cnt to 0.
- Byte count for the accepted word:
  - in_last=0: 4 (in_bytes ignored).
  - in_last=1: in_bytes; values 5..7 saturate to 4.
- Block length: len = 4*(words before the last) + bytes of the last word; 5-bit result, no wrap possible.
- Padding, applied when len<16:
  - Bytes at index >= len are zeroed, including invalid bytes of the last word.
  - Byte 15 (out_pdi[7:0]) is set to len.
  - out_padded=1.
- When len=16 there is no padding and out_padded=0.
- out_decrypt bit for byte i = in_decrypt AND (i<len); padded bytes and the length byte are always 0.
- out_last=1 if the block was closed by in_last. A full 4-word block closed with in_last=1, in_bytes=4 gives out_last=1, out_padded=0.
- Empty segment (in_last=1, in_bytes=0 at cnt=0): block is all zeros, len=0, out_padded=1, decrypt mask 0.
- HOLD: outputs stay stable until out_ready. On out_valid&out_ready, go to FILL next cycle with out_valid=0.
- Latency: block valid 1 cycle after its final word is accepted. Throughput is 1 block per 5 cycles without the optional feature.
- in_valid with in_ready=0 causes no side effect; the source must hold the word.

Optional Feature:
- Macro: ROMULUS_PDI_LOADER_SKID_EN.
- Defined:
  - in_ready = FILL | (HOLD & out_ready).
  - A word accepted in the cycle the held block is consumed is written into slot 0 of the next block. The FSM goes to FILL with cnt=1, or straight back to HOLD if that word has in_last=1.
  - Throughput becomes 1 block per 4 cycles.
- Undefined: behaviour exactly as above; in_ready is never 1 in HOLD.

Decomposition:
- Shared package romulus_config_pkg.v: BUSW and the FSM state encodings FILL=1'b0, HOLD=1'b1.
- One natural sub-module, romulus_pad_mask: combinational; maps len[4:0] to a 16-bit valid-byte mask used for zeroing, length-byte insertion and decrypt masking.

Test Plan:
- Full block: 4 words 0x00010203, 0x04050607, 0x08090A0B, 0x0C0D0E0F, last on the 4th with in_bytes=4, in_decrypt=0 -> out_pdi=0x000102...0F, len=16, padded=0, last=1, decrypt=0x0000.
- Partial block: words 0xA1A2A3A4, 0xB1B2B3B4, then last with in_bytes=1 and data 0xC1xxxxxx, in_decrypt=1 -> out_pdi=0xA1A2A3A4_B1B2B3B4_C1000000_00000009, len=9, padded=1, decrypt=0xFF80.
- Empty segment: single word with in_last=1, in_bytes=0 -> out_pdi=0, len=0, padded=1, last=1, decrypt=0.
- Backpressure: hold out_ready=0 for 10 cycles with in_valid=1 -> in_ready=0, out_pdi stable, no word lost. Release -> next block correct, 5-cycle spacing (4 with SKID_EN).
- Reset mid-block after 2 words, then a 4-word block -> output contains only the new words, len=16.
- Saturation: in_last=1 with in_bytes=7 at cnt=3 -> treated as 4, len=16, padded=0.
